// File: rtl/pipeline_fetch_unit.sv
// pipeline_fetch_unit
//   Instruction-fetch stage plus the IF/ID pipeline register. Owns the PC and
//   the instruction-memory request/ready handshake. Inserts bubbles on
//   redirects and memory wait states, and parks a word fetched during an ID
//   stall in a one-entry skid buffer.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   imem_req            fetch request, asserted only in FETCH
//   imem_addr           fetch address, always equal to the PC
//   imem_rdata          instruction word, valid when imem_ready=1
//   imem_ready          memory completed the current request
//   shouldStall         ID stage cannot accept a new instruction
//   shouldJumpOrBranch  redirect the PC to branchTarget (highest priority)
//   branchTarget        redirect address, low two bits forced to zero
//   id_instruction      IF/ID instruction word (NOP_WORD for a bubble)
//   id_pc, id_pcPlus4   address of id_instruction and that address + 4
//   id_valid            IF/ID holds a real instruction
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | just out of reset, no request; moves to S_FETCH next edge
// S_FETCH | request outstanding at PC, waiting for imem_ready
// S_HELD  | fetched word parked in skid buffer while ID stalls; no request
module pipeline_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] branchTarget,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcPlus4,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_imem_req;
  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic        r_id_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic [1:0]  w_unused_tgt_lsbs;

  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_target          = {branchTarget[31:2], 2'b00};
  assign w_unused_tgt_lsbs = branchTarget[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_imem_req   <= 1'b0;
      r_pc         <= RESET_PC;
      r_id_instr   <= NOP_WORD;
      r_id_pc      <= 32'd0;
      r_id_pc4     <= 32'd0;
      r_id_valid   <= 1'b0;
      r_skid_instr <= NOP_WORD;
      r_skid_pc    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end

        S_FETCH, S_HELD: begin
          if (shouldJumpOrBranch) begin
            // Redirect beats stall; dropping the request cancels any
            // response arriving in this cycle, and the skid entry is lost.
            r_pc       <= w_target;
            r_id_instr <= NOP_WORD;
            r_id_valid <= 1'b0;
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end else if (r_state == S_HELD) begin
            if (!shouldStall) begin
              // PC still points at the parked word, so PC+4 is its link.
              r_id_instr <= r_skid_instr;
              r_id_pc    <= r_skid_pc;
              r_id_pc4   <= w_pc_plus4;
              r_id_valid <= 1'b1;
              r_pc       <= w_pc_plus4;
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
            end
          end else if (imem_ready) begin
            if (shouldStall) begin
              r_skid_instr <= imem_rdata;
              r_skid_pc    <= r_pc;
              r_state      <= S_HELD;
              r_imem_req   <= 1'b0;
            end else begin
              r_id_instr <= imem_rdata;
              r_id_pc    <= r_pc;
              r_id_pc4   <= w_pc_plus4;
              r_id_valid <= 1'b1;
              r_pc       <= w_pc_plus4;
            end
          end else if (!shouldStall) begin
            // ID consumed the previous entry and nothing new arrived.
            r_id_instr <= NOP_WORD;
            r_id_valid <= 1'b0;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req       = r_imem_req;
  assign imem_addr      = r_pc;
  assign id_instruction = r_id_instr;
  assign id_pc          = r_id_pc;
  assign id_pcPlus4     = r_id_pc4;
  assign id_valid       = r_id_valid;

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
module tb_pipeline_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ready = 1'b0;
  logic        shouldStall = 1'b0;
  logic        shouldJumpOrBranch = 1'b0;
  logic [31:0] branchTarget = 32'd0;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pcPlus4;
  logic        id_valid;

  int n_total = 0;
  int n_bad   = 0;

  pipeline_fetch_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_rdata         (imem_rdata),
    .imem_ready         (imem_ready),
    .shouldStall        (shouldStall),
    .shouldJumpOrBranch (shouldJumpOrBranch),
    .branchTarget       (branchTarget),
    .id_instruction     (id_instruction),
    .id_pc              (id_pc),
    .id_pcPlus4         (id_pcPlus4),
    .id_valid           (id_valid)
  );

  always #5 clk = ~clk;

  // Reference model: a running/parked description of the fetch stage.
  bit          m_run;
  bit          m_parked;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_idpc4;
  bit          m_valid;
  logic [31:0] m_buf_word;
  logic [31:0] m_buf_pc;

  typedef struct {
    bit          stall;
    bit          jb;
    logic [31:0] tgt;
    bit          ready;
    logic [31:0] rdata;
    bit          e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    bit          e_valid;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_parked = 0; m_pc = 32'd0;
    m_instr = 32'd0; m_idpc = 32'd0; m_idpc4 = 32'd0; m_valid = 0;
    m_buf_word = 32'd0; m_buf_pc = 32'd0;
  endtask

  task automatic model_step(input bit s, input bit j, input logic [31:0] t,
                            input bit r, input logic [31:0] d);
    if (!m_run) begin
      m_run = 1;
    end else if (j) begin
      m_pc = t & 32'hFFFF_FFFC;
      m_instr = 32'd0; m_valid = 0; m_parked = 0;
    end else if (m_parked) begin
      if (!s) begin
        m_instr = m_buf_word; m_idpc = m_buf_pc; m_idpc4 = m_buf_pc + 32'd4;
        m_valid = 1; m_pc = m_pc + 32'd4; m_parked = 0;
      end
    end else if (r) begin
      if (s) begin
        m_buf_word = d; m_buf_pc = m_pc; m_parked = 1;
      end else begin
        m_instr = d; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
        m_valid = 1; m_pc = m_pc + 32'd4;
      end
    end else if (!s) begin
      m_instr = 32'd0; m_valid = 0;
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, (m_run && !m_parked)});
    chk({tag, ".addr"},  imem_addr, m_pc);
    chk({tag, ".instr"}, id_instruction, m_instr);
    chk({tag, ".pc"},    id_pc, m_idpc);
    chk({tag, ".pc4"},   id_pcPlus4, m_idpc4);
    chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, m_valid});
  endtask

  // Called at a falling edge: drive, let one rising edge pass, return at
  // the next falling edge with the model advanced.
  task automatic drive_cycle(input bit s, input bit j, input logic [31:0] t,
                             input bit r, input logic [31:0] d);
    shouldStall = s; shouldJumpOrBranch = j; branchTarget = t;
    imem_ready = r; imem_rdata = d;
    @(posedge clk);
    model_step(s, j, t, r, d);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, ".addr"},  imem_addr, 32'd0);
    chk({tag, ".instr"}, id_instruction, 32'd0);
    chk({tag, ".pc"},    id_pc, 32'd0);
    chk({tag, ".pc4"},   id_pcPlus4, 32'd0);
    chk({tag, ".valid"}, {31'd0, id_valid}, 32'd0);
  endtask

  initial begin
    //            stall jb  tgt          rdy rdata         req addr          instr         pc            pc4           valid
    vecs[0] = '{0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        32'h0,        0};
    vecs[1] = '{0, 0, 32'h0,        1, 32'hA000_0000, 1, 32'h4,        32'hA000_0000, 32'h0,        32'h4,        1};
    vecs[2] = '{0, 0, 32'h0,        1, 32'hA000_0004, 1, 32'h8,        32'hA000_0004, 32'h4,        32'h8,        1};
    vecs[3] = '{0, 0, 32'h0,        0, 32'h1111_1111, 1, 32'h8,        32'h0,        32'h4,        32'h8,        0};
    vecs[4] = '{1, 0, 32'h0,        1, 32'hA000_0008, 0, 32'h8,        32'h0,        32'h4,        32'h8,        0};
    vecs[5] = '{1, 0, 32'h0,        0, 32'h0,        0, 32'h8,        32'h0,        32'h4,        32'h8,        0};
    vecs[6] = '{0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        32'hA000_0008, 32'h8,        32'hC,        1};
    vecs[7] = '{1, 1, 32'h103,      1, 32'hDEAD_BEEF, 1, 32'h100,      32'h0,        32'h8,        32'hC,        0};
    vecs[8] = '{0, 0, 32'h0,        1, 32'hA000_0100, 1, 32'h104,      32'hA000_0100, 32'h100,      32'h104,      1};
    vecs[9] = '{1, 0, 32'h0,        0, 32'h0,        1, 32'h104,      32'hA000_0100, 32'h100,      32'h104,      1};

    model_reset();
    @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    chk({"rst.release_req"}, {31'd0, imem_req}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      drive_cycle(vecs[i].stall, vecs[i].jb, vecs[i].tgt, vecs[i].ready, vecs[i].rdata);
      chk($sformatf("vec%0d.req", i),   {31'd0, imem_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("vec%0d.addr", i),  imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d.instr", i), id_instruction, vecs[i].e_instr);
      chk($sformatf("vec%0d.pc", i),    id_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.pc4", i),   id_pcPlus4, vecs[i].e_pc4);
      chk($sformatf("vec%0d.valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
    end

    // Redirect while parked: the buffered word must never reach ID.
    drive_cycle(1, 0, 32'h0, 1, 32'hA000_0104);
    chk("held.req", {31'd0, imem_req}, 32'd0);
    cmp_model("held");
    drive_cycle(1, 1, 32'h200, 0, 32'h0);
    chk("held_jb.addr", imem_addr, 32'h200);
    chk("held_jb.valid", {31'd0, id_valid}, 32'd0);
    cmp_model("held_jb");
    drive_cycle(0, 0, 32'h0, 1, 32'hA000_0200);
    chk("held_jb.next_pc", id_pc, 32'h200);
    chk("held_jb.next_instr", id_instruction, 32'hA000_0200);
    cmp_model("held_jb2");

    // PC wraparound at the top of the address space.
    drive_cycle(0, 1, 32'hFFFF_FFFE, 1, 32'h0000_0BAD);
    chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    drive_cycle(0, 0, 32'h0, 1, 32'h1234_5678);
    chk("wrap.pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap.pc4", id_pcPlus4, 32'h0);
    chk("wrap.addr0", imem_addr, 32'h0);
    drive_cycle(0, 0, 32'h0, 1, 32'hA000_0000);
    cmp_model("wrap2");

    // Reset while a request is outstanding.
    drive_cycle(0, 0, 32'h0, 0, 32'h0);
    chk("midrst.pre_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.release_req", {31'd0, imem_req}, 32'd0);
    drive_cycle(0, 0, 32'h0, 0, 32'h0);
    chk("midrst.restart_req", {31'd0, imem_req}, 32'd1);
    chk("midrst.restart_addr", imem_addr, 32'h0);

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_model("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        bit          s, j, r;
        logic [31:0] t, d;
        s = ($urandom_range(0, 3) == 0);
        j = ($urandom_range(0, 9) == 0);
        r = ($urandom_range(0, 9) < 7);
        t = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
        d = r ? (imem_addr | 32'hA000_0000) : $urandom;
        drive_cycle(s, j, t, r, d);
        cmp_model("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_fetch_unit.md
# pipeline_fetch_unit

Instruction-fetch (IF) stage and IF/ID pipeline register for the five-stage pipelined CPU. It produces the instruction word that the ID-stage control decoder consumes, and acts on the decoder's `shouldStall` and `shouldJumpOrBranch` outputs. It owns the PC and the instruction-memory request/ready handshake, and inserts bubbles on redirects and on memory wait states.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_WORD`, default 32'h0000_0000: bubble instruction (`sll $0,$0,0`).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  32: fetch address; always equal to the PC.
- `imem_rdata`  in  32: instruction word; valid only when `imem_ready`=1.
- `imem_ready`  in  1: memory has completed the current request (MIO_ready style).
- `shouldStall`  in  1: ID stage cannot accept a new instruction.
- `shouldJumpOrBranch`  in  1: redirect the PC to `branchTarget`.
- `branchTarget`  in  32: redirect address; bits [1:0] are ignored and forced to 0.
- `id_instruction`  out  32: IF/ID instruction.
- `id_pc`  out  32: address of `id_instruction`.
- `id_pcPlus4`  out  32: `id_pc`+4, used by jal link and branch offsets.
- `id_valid`  out  1: IF/ID holds a real instruction, not a bubble.

## Operation
- State machine has three states: IDLE, FETCH, HELD.
- IDLE: entered only by reset. `imem_req`=0. Moves unconditionally to FETCH on the next edge.
- FETCH: `imem_req`=1, `imem_addr`=PC, held stable until `imem_ready` or redirect.
- Priority on each edge: redirect > stall > normal.
- Redirect (`shouldJumpOrBranch`=1), in any non-IDLE state:
  - PC <= {`branchTarget`[31:2],2'b00}.
  - IF/ID <= bubble: `id_instruction`=`NOP_WORD`, `id_valid`=0, pc fields unchanged.
  - Skid buffer discarded; state <= FETCH.
  - Any `imem_ready`/`imem_rdata` in that cycle is ignored. Dropping `imem_req` cancels the request (memory contract).
- FETCH, `imem_ready`=1, no stall:
  - IF/ID <= {`imem_rdata`, PC, PC+4, valid=1}.
  - PC <= PC+4.
- FETCH, `imem_ready`=1, stall:
  - IF/ID held; word, PC and PC+4 captured into the skid buffer.
  - PC unchanged; state <= HELD.
- FETCH, `imem_ready`=0:
  - With no stall: IF/ID <= bubble, because ID consumed the previous entry.
  - With stall: IF/ID held.
- HELD: `imem_req`=0. While stall: hold everything. When stall drops: IF/ID <= buffer with valid=1, PC <= PC+4, state <= FETCH.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values (asynchronous): state=IDLE, PC=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `id_instruction`=`NOP_WORD`, `id_pc`=0, `id_pcPlus4`=0, `id_valid`=0, skid buffer empty.
- After `rst_n` rises, the first request is issued one cycle later (IDLE→FETCH).
- Zero-wait memory: one instruction per cycle. A word presented at cycle N is on the IF/ID outputs after edge N.
- Wait states: each cycle with `imem_ready`=0 and no stall produces one bubble.
- Redirect asserted in cycle N: `imem_addr`=target in N+1. With zero-wait memory the target instruction is valid in ID after edge N+1. Exactly one bubble follows a taken branch or jump.
- Reset mid-fetch or mid-HELD: immediate asynchronous return to reset values; the outstanding request is dropped.
- `imem_req`, `imem_addr` and `id_*` are functions of state and registers only. No combinational path from `shouldStall` to `imem_req`.

## Test plan
- Reset then zero-wait memory returning addr|0xA000_0000: `id_pc` steps 0, 4, 8, … each cycle with `id_valid`=1; `id_instruction`=0xA000_0004 when `id_pc`=4.
- 2 wait cycles at PC=0x10 (`imem_ready`=0): `imem_addr` stays 0x10 for 3 cycles; two bubbles appear (`id_valid`=0, `id_instruction`=0); then `id_pc`=0x10.
- Stall for 3 cycles while `imem_ready`=1 at PC=0x20: IF/ID keeps 0x1C; state HELD with `imem_req`=0; after release `id_pc`=0x20, then `imem_addr`=0x24.
- Redirect to 0x0000_0103 together with stall at PC=0x40: redirect wins; next `imem_addr`=0x100; one bubble; then `id_pc`=0x100, `id_pcPlus4`=0x104.
- Redirect while in HELD holding 0x60: buffered word never reaches ID; next valid `id_pc` equals the target.
- `rst_n` pulsed low while `imem_req`=1 and `imem_ready`=0: outputs return to reset values immediately; `imem_req`=0 for one cycle after release, then fetch restarts at `RESET_PC`.
